// File: rtl/fetch_if.sv
// Fetch-side bus bundle: instruction-memory address/data, branch redirect and
// the decode-facing valid/ready head port of the prefetch queue.
interface fetch_if #(
   parameter int DEPTH = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [31:0]      pc_addr_o;
   logic [31:0]      instr_i;
   logic             redirect_i;
   logic [31:0]      redirect_pc_i;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [31:0]      instr_o;
   logic [31:0]      instr_pc_o;
   logic [CNT_W-1:0] count_o;
   logic             end_o;

   modport master (
      output pc_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o, end_o,
      input  instr_i, redirect_i, redirect_pc_i, instr_ready_i
   );

   modport slave (
      input  pc_addr_o, instr_valid_o, instr_o, instr_pc_o, count_o, end_o,
      output instr_i, redirect_i, redirect_pc_i, instr_ready_i
   );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: walks the instruction memory, buffers {pc, word} pairs in a
// small FIFO for decode, and restarts from a new PC on branch redirect.
module instr_fetch_ctrl #(
   parameter int          DEPTH     = 4,
   parameter int          MEM_WORDS = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic     clk_i,
   input  logic     rst_i,
   fetch_if.master  bus
);
   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [31:0]      LAST_PC = 32'((MEM_WORDS - 1) * 4);
   localparam logic [31:0]      END_PC  = 32'(MEM_WORDS * 4);
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);

   typedef enum logic {
      S_FETCH,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [31:0]      fetch_pc, fetch_pc_nxt;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [CNT_W-1:0] count, count_nxt;

   logic [31:0]      q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];

   logic             head_valid;
   logic             push;
   logic             pop;
   logic [31:0]      redirect_target;
   logic             unused_bits;

   // Low two bits of the redirect target are byte offsets and never reach the PC.
   assign unused_bits     = &{1'b0, bus.redirect_pc_i[1:0]};
   assign redirect_target = {bus.redirect_pc_i[31:2], 2'b00};

   assign head_valid = (count != '0) && !bus.redirect_i;
   assign pop        = head_valid && bus.instr_ready_i;
   assign push       = (state == S_FETCH) && !bus.redirect_i && ((count < FULL) || pop);

   always_comb begin
      // NOTE: every next-state value gets a default first, so no path leaves a
      // signal unassigned and no latch is inferred.
      state_nxt    = state;
      fetch_pc_nxt = fetch_pc;
      rd_ptr_nxt   = rd_ptr;
      wr_ptr_nxt   = wr_ptr;
      count_nxt    = count;

      if (bus.redirect_i) begin
         rd_ptr_nxt   = '0;
         wr_ptr_nxt   = '0;
         count_nxt    = '0;
         fetch_pc_nxt = redirect_target;
         state_nxt    = (redirect_target < END_PC) ? S_FETCH : S_DONE;
      end else begin
         if (push) begin
            wr_ptr_nxt   = wr_ptr + 1'b1;
            fetch_pc_nxt = fetch_pc + 32'd4;
            if (fetch_pc == LAST_PC) begin
               state_nxt = S_DONE;
            end
         end
         if (pop) begin
            rd_ptr_nxt = rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (!rst_i) begin
         state    <= S_FETCH;
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         state    <= state_nxt;
         fetch_pc <= fetch_pc_nxt;
         rd_ptr   <= rd_ptr_nxt;
         wr_ptr   <= wr_ptr_nxt;
         count    <= count_nxt;
      end
   end

   // NOTE: queue storage is deliberately not reset; count gates every read, so
   // stale contents are never visible and the array stays plain RAM.
   always_ff @(posedge clk_i) begin
      if (push) begin
         q_pc[wr_ptr]    <= fetch_pc;
         q_instr[wr_ptr] <= bus.instr_i;
      end
   end

   assign bus.pc_addr_o     = fetch_pc;
   assign bus.instr_valid_o = head_valid;
   assign bus.instr_o       = head_valid ? q_instr[rd_ptr] : 32'h0;
   assign bus.instr_pc_o    = head_valid ? q_pc[rd_ptr]    : 32'h0;
   assign bus.count_o       = count;
   assign bus.end_o         = (state == S_DONE) && (count == '0);

   a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_i) count <= FULL);
   a_pc_aligned  : assert property (@(posedge clk_i) disable iff (!rst_i) fetch_pc[1:0] == 2'b00);
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: expected decode-side instructions go into
// a scoreboard queue and an independent monitor compares each accepted head.
module tb_instr_fetch_ctrl;
   localparam int DEPTH = 4;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;

   fetch_if #(.DEPTH(DEPTH)) bus ();

   instr_fetch_ctrl #(
      .DEPTH     (DEPTH),
      .MEM_WORDS (32),
      .RESET_PC  (32'h0)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   // Instruction memory contents: known program words plus a tagged filler.
   function automatic logic [31:0] mem_word(input logic [4:0] idx);
      case (idx)
         5'd0:    return 32'h0000_4020;
         5'd1:    return 32'h2009_000A;
         5'd10:   return 32'h8D0B_0000;
         default: return {16'hC0DE, 11'd0, idx};
      endcase
   endfunction

   assign bus.instr_i = mem_word(bus.pc_addr_o[6:2]);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_seq(input logic [31:0] start, input int n);
      logic [31:0] pc;
      for (int k = 0; k < n; k++) begin
         pc = start + 32'(4 * k);
         sb.push_back('{pc: pc, instr: mem_word(pc[6:2])});
      end
   endtask

   // Monitor: any head accepted by decode must match the scoreboard front.
   always @(negedge clk_i) begin
      if (bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i) begin
         check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("head_pc", bus.instr_pc_o, mon_e.pc);
            check("head_instr", bus.instr_o, mon_e.instr);
         end
      end else if (!bus.instr_valid_o) begin
         check("idle_zero", bus.instr_o | bus.instr_pc_o, 32'h0);
      end
   end

   // All stimulus tasks start and end just after a rising edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset(input logic ready);
      rst_i             = 1'b0;
      bus.instr_ready_i = ready;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;
      #1;
      check("rst_pc_addr", bus.pc_addr_o, 32'h0);
      check("rst_valid", 32'(bus.instr_valid_o), 32'd0);
      check("rst_instr", bus.instr_o, 32'h0);
      check("rst_instr_pc", bus.instr_pc_o, 32'h0);
      check("rst_count", 32'(bus.count_o), 32'd0);
      check("rst_end", 32'(bus.end_o), 32'd0);
      tick(2);
      rst_i = 1'b1;
   endtask

   task automatic run_ready(input int n);
      bus.instr_ready_i = 1'b1;
      repeat (n) begin
         @(negedge clk_i);
         check("stream_valid", 32'(bus.instr_valid_o), 32'd1);
         @(posedge clk_i);
         #1;
      end
      bus.instr_ready_i = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] pc);
      bus.redirect_i    = 1'b1;
      bus.redirect_pc_i = pc;
      @(negedge clk_i);
      check("redir_valid_low", 32'(bus.instr_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      bus.redirect_i = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.instr_ready_i = 1'b0;
      bus.redirect_i    = 1'b0;
      bus.redirect_pc_i = 32'h0;

      // 1: streaming from reset, one instruction per cycle
      do_reset(1'b1);
      expect_seq(32'h0, 8);
      @(negedge clk_i);
      check("latency_pre", 32'(bus.instr_valid_o), 32'd0);
      @(posedge clk_i);
      #1;
      run_ready(8);
      check("t1_drained", 32'(sb.size()), 32'd0);

      // 2: full queue stalls fetch, then drains without gap or duplicate
      do_reset(1'b0);
      tick(10);
      check("t2_count_full", 32'(bus.count_o), 32'd4);
      check("t2_pc_hold", bus.pc_addr_o, 32'h10);
      check("t2_valid", 32'(bus.instr_valid_o), 32'd1);
      expect_seq(32'h0, 6);
      run_ready(6);
      check("t2_drained", 32'(sb.size()), 32'd0);

      // 3: redirect with three entries queued, unaligned target
      do_reset(1'b0);
      tick(3);
      check("t3_count", 32'(bus.count_o), 32'd3);
      bus.instr_ready_i = 1'b1;
      pulse_redirect(32'h2A);
      check("t3_flushed", 32'(bus.count_o), 32'd0);
      check("t3_pc_addr", bus.pc_addr_o, 32'h28);
      expect_seq(32'h28, 3);
      tick(1);
      run_ready(3);
      check("t3_drained", 32'(sb.size()), 32'd0);

      // 4: run to the end of memory, then redirect back to 0
      do_reset(1'b1);
      expect_seq(32'h0, 32);
      tick(1);
      run_ready(32);
      check("t4_end", 32'(bus.end_o), 32'd1);
      check("t4_pc_addr", bus.pc_addr_o, 32'h80);
      check("t4_count", 32'(bus.count_o), 32'd0);
      tick(5);
      check("t4_pc_hold", bus.pc_addr_o, 32'h80);
      check("t4_end_hold", 32'(bus.end_o), 32'd1);
      check("t4_drained", 32'(sb.size()), 32'd0);
      expect_seq(32'h0, 3);
      pulse_redirect(32'h0);
      check("t4_restart_end", 32'(bus.end_o), 32'd0);
      tick(1);
      run_ready(3);
      check("t4_restart_drained", 32'(sb.size()), 32'd0);

      // 5: redirect to out-of-range target goes straight to DONE
      bus.instr_ready_i = 1'b1;
      pulse_redirect(32'h80);
      check("t5_end", 32'(bus.end_o), 32'd1);
      check("t5_pc_addr", bus.pc_addr_o, 32'h80);
      repeat (6) begin
         @(negedge clk_i);
         check("t5_no_valid", 32'(bus.instr_valid_o), 32'd0);
         @(posedge clk_i);
         #1;
      end
      bus.instr_ready_i = 1'b0;

      // 6: asynchronous reset in mid-cycle with a full queue
      do_reset(1'b0);
      tick(6);
      check("t6_full", 32'(bus.count_o), 32'd4);
      #2;
      rst_i = 1'b0;
      #1;
      check("t6_async_valid", 32'(bus.instr_valid_o), 32'd0);
      check("t6_async_count", 32'(bus.count_o), 32'd0);
      check("t6_async_pc", bus.pc_addr_o, 32'h0);
      tick(1);
      rst_i = 1'b1;
      tick(1);
      check("t6_refill_count", 32'(bus.count_o), 32'd1);
      check("t6_refill_pc", bus.instr_pc_o, 32'h0);
      check("t6_refill_instr", bus.instr_o, 32'h0000_4020);

      check("final_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
